// File: rtl/adder_pipe_pkg.sv
// Shared constants for the pipelined adder and the datapath that embeds it.
package adder_pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_CHUNK = 8;

    // Number of pipeline stages: one slice of CHUNK bits resolved per stage.
    function automatic int unsigned num_stages(input int unsigned width,
                                               input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit slice adder; reports the carry into its MSB so the
// top slice can derive signed overflow.
module adder_chunk import adder_pipe_pkg::*; #(
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    // Slice sum with the carry-out kept as the extra top bit
    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        s     = full[CHUNK-1:0];
        cout  = full[CHUNK];
        // Carry into the MSB recovered from that bit's sum
        c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one CHUNK-bit slice per stage with the carry
// registered between stages, valid/ready on both sides, whole-pipe stall.
module adder_pipe import adder_pipe_pkg::*; #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned S = num_stages(WIDTH, CHUNK);

    if (WIDTH == 0 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("adder_pipe: WIDTH must be a positive multiple of CHUNK");
    end

    logic             advance;
    logic             accept;

    // Stage registers; stage S-1 drives the outputs directly
    logic             valid_q [S];
    logic [WIDTH-1:0] a_q     [S];
    logic [WIDTH-1:0] b_q     [S];
    logic [WIDTH-1:0] res_q   [S];
    logic             carry_q [S];
    logic             ovf_q;
    logic             zero_q;

    // Per-stage combinational inputs and results
    logic             st_v     [S];
    logic [WIDTH-1:0] st_a     [S];
    logic [WIDTH-1:0] st_b     [S];
    logic [WIDTH-1:0] st_res   [S];
    logic             st_c     [S];
    logic [WIDTH-1:0] res_nxt  [S];
    logic [CHUNK-1:0] chunk_s  [S];
    logic             chunk_co [S];
    logic             chunk_cm [S];

    // A full output register blocks everything behind it; bubbles are not collapsed
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !reset;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < S; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtract as a + ~b + !cin
            assign st_v[k]   = accept;
            assign st_a[k]   = a;
            assign st_b[k]   = sub ? ~b : b;
            assign st_c[k]   = cin ^ sub;
            assign st_res[k] = '0;
        end else begin : g_next
            assign st_v[k]   = valid_q[k-1];
            assign st_a[k]   = a_q[k-1];
            assign st_b[k]   = b_q[k-1];
            assign st_c[k]   = carry_q[k-1];
            assign st_res[k] = res_q[k-1];
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a     (st_a[k][k*CHUNK +: CHUNK]),
            .b     (st_b[k][k*CHUNK +: CHUNK]),
            .cin   (st_c[k]),
            .s     (chunk_s[k]),
            .cout  (chunk_co[k]),
            .c_msb (chunk_cm[k])
        );

        // Slices above k are still zero in st_res, so OR merges the new slice
        assign res_nxt[k] = st_res[k] | (WIDTH'(chunk_s[k]) << (k * CHUNK));
    end

    // Whole pipe shifts on advance; data registers load only behind a valid beat
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < S; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                res_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < S; k++) begin
                valid_q[k] <= st_v[k];
                if (st_v[k]) begin
                    a_q[k]     <= st_a[k];
                    b_q[k]     <= st_b[k];
                    res_q[k]   <= res_nxt[k];
                    carry_q[k] <= chunk_co[k];
                end
            end
            if (st_v[S-1]) begin
                ovf_q  <= chunk_cm[S-1] ^ chunk_co[S-1];
                zero_q <= (res_nxt[S-1] == '0);
            end
        end
    end

    assign out_valid = valid_q[S-1];
    assign sum       = res_q[S-1];
    assign cout      = carry_q[S-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: vector table, streaming with backpressure,
// reset with beats in flight, and two alternative parameterisations.
module tb_adder_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Default 32/8 instance
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;

    adder_pipe u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    // 16/16 instance: single stage
    logic        w16_in_valid, w16_in_ready, w16_cin, w16_sub, w16_out_valid, w16_out_ready;
    logic        w16_cout, w16_ovf, w16_zero;
    logic [15:0] w16_a, w16_b, w16_sum;

    adder_pipe #(
        .WIDTH (16),
        .CHUNK (16)
    ) u_w16 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w16_in_valid),
        .in_ready  (w16_in_ready),
        .a         (w16_a),
        .b         (w16_b),
        .cin       (w16_cin),
        .sub       (w16_sub),
        .out_valid (w16_out_valid),
        .out_ready (w16_out_ready),
        .sum       (w16_sum),
        .cout      (w16_cout),
        .ovf       (w16_ovf),
        .zero      (w16_zero)
    );

    // 64/8 instance: eight stages
    logic        w64_in_valid, w64_in_ready, w64_cin, w64_sub, w64_out_valid, w64_out_ready;
    logic        w64_cout, w64_ovf, w64_zero;
    logic [63:0] w64_a, w64_b, w64_sum;

    adder_pipe #(
        .WIDTH (64),
        .CHUNK (8)
    ) u_w64 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (w64_in_valid),
        .in_ready  (w64_in_ready),
        .a         (w64_a),
        .b         (w64_b),
        .cin       (w64_cin),
        .sub       (w64_sub),
        .out_valid (w64_out_valid),
        .out_ready (w64_out_ready),
        .sum       (w64_sum),
        .cout      (w64_cout),
        .ovf       (w64_ovf),
        .zero      (w64_zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference result from a direct add or subtract, not via a + ~b + !cin
    task automatic ref_calc(input int unsigned w, input logic [63:0] x, input logic [63:0] y,
                            input logic c, input logic s,
                            output logic [63:0] r, output logic co);
        logic [64:0] full;
        logic [64:0] mask;
        mask = (65'd1 << w) - 65'd1;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y} + 65'(c);
            co   = full[w];
        end else begin
            full = {1'b0, x} - {1'b0, y} - 65'(c);
            co   = ({1'b0, x} >= ({1'b0, y} + 65'(c)));
        end
        r = 64'(full & mask);
    endtask

    // Send one beat on the default instance and check latency and flags.
    // Starts and ends 1 time unit after a rising edge.
    task automatic send_beat(input vec_t v, input string tag);
        int n;
        a         = v.a;
        b         = v.b;
        cin       = v.cin;
        sub       = v.sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 16) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd3);
        check({tag, "_sum"}, 64'(sum), 64'(v.exp_sum));
        check({tag, "_cout"}, 64'(cout), 64'(v.exp_cout));
        check({tag, "_ovf"}, 64'(ovf), 64'(v.exp_ovf));
        check({tag, "_zero"}, 64'(zero), 64'(v.exp_zero));
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs [9];
    vec_t        post_rst;
    logic [31:0] exp_q [$];
    logic [31:0] sa, sb, held, exp_v;
    logic        stalled;
    int          beat, got, cyc, spurious, n;
    logic [63:0] ra, rb, es;
    logic        rc, rs, ec;

    initial begin
        in_valid      = 1'b0;
        a             = '0;
        b             = '0;
        cin           = 1'b0;
        sub           = 1'b0;
        out_ready     = 1'b1;
        w16_in_valid  = 1'b0;
        w16_a         = '0;
        w16_b         = '0;
        w16_cin       = 1'b0;
        w16_sub       = 1'b0;
        w16_out_ready = 1'b1;
        w64_in_valid  = 1'b0;
        w64_a         = '0;
        w64_b         = '0;
        w64_cin       = 1'b0;
        w64_sub       = 1'b0;
        w64_out_ready = 1'b1;

        //            a             b             cin   sub   sum           cout  ovf   zero
        vecs[0] = '{32'h0000_0000, 32'h0000_000F, 1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'h1234_5678, 32'h0000_00FF, 1'b1, 1'b0, 32'h1234_5778, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        post_rst = '{32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, 32'h0000_0123, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            send_beat(vecs[i], $sformatf("vec%0d", i));
        end

        // Streaming 100 beats under random backpressure
        sa      = 32'h0;
        sb      = 32'hF;
        beat    = 0;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (got < 100 && cyc < 3000) begin
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_sum", 64'(sum), 64'(held));
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (beat < 100);
            a         = sa;
            b         = sb;
            cin       = 1'b0;
            sub       = 1'b0;
            #1;
            stalled = out_valid && !out_ready;
            if (stalled) begin
                held = sum;
                check("stall_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("stream%0d_sum", got), 64'(sum), 64'(exp_v));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(sa + sb);
                beat++;
                sa = sa + 32'h1FFF_FFFF;
                sb = sb + 32'h1FFF_FFFF;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 64'(got), 64'd100);
        repeat (6) @(posedge clk);
        #1;

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            a        = 32'h200 + 32'(i);
            b        = 32'h1;
            cin      = 1'b0;
            sub      = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        reset    = 1'b0;
        spurious = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious++;
        end
        check("midrst_no_stale", 64'(spurious), 64'd0);
        send_beat(post_rst, "post_rst");

        // WIDTH=16, CHUNK=16: latency 1 (valid right after the accept edge)
        for (int i = 0; i < 8; i++) begin
            ra = 64'($urandom_range(0, 65535));
            rb = 64'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ref_calc(16, ra, rb, rc, rs, es, ec);
            w16_a        = ra[15:0];
            w16_b        = rb[15:0];
            w16_cin      = rc;
            w16_sub      = rs;
            w16_in_valid = 1'b1;
            #1;
            check("w16_in_ready", 64'(w16_in_ready), 64'd1);
            @(posedge clk);
            #1;
            w16_in_valid = 1'b0;
            n = 0;
            while (!w16_out_valid && n < 16) begin
                @(posedge clk);
                #1;
                n++;
            end
            check($sformatf("w16_%0d_latency", i), 64'(n), 64'd0);
            check($sformatf("w16_%0d_sum", i), 64'(w16_sum), es);
            check($sformatf("w16_%0d_cout", i), 64'(w16_cout), 64'(ec));
            @(posedge clk);
            #1;
        end

        // WIDTH=64, CHUNK=8: eight stages
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            ref_calc(64, ra, rb, rc, rs, es, ec);
            w64_a        = ra;
            w64_b        = rb;
            w64_cin      = rc;
            w64_sub      = rs;
            w64_in_valid = 1'b1;
            #1;
            check("w64_in_ready", 64'(w64_in_ready), 64'd1);
            @(posedge clk);
            #1;
            w64_in_valid = 1'b0;
            n = 0;
            while (!w64_out_valid && n < 32) begin
                @(posedge clk);
                #1;
                n++;
            end
            check($sformatf("w64_%0d_latency", i), 64'(n), 64'd7);
            check($sformatf("w64_%0d_sum", i), w64_sum, es);
            check($sformatf("w64_%0d_cout", i), 64'(w64_cout), 64'(ec));
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract unit that succeeds the single-cycle 32-bit ripple adder. Operands split into CHUNK-bit slices; one slice is resolved per pipeline stage, with the carry registered between stages, so clock rate is independent of WIDTH. A valid/ready handshake on both sides lets it sit between the CPU datapath's operand registers and its write-back stage and absorb write-back stalls. Adds subtract mode, a signed-overflow flag and a zero flag.

## Interface
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 8, bits resolved per stage; S = WIDTH/CHUNK stages (4 by default)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit accepts a beat this cycle
- a, b  input  WIDTH  unsigned/two's-complement operands
- cin  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0: a+b+cin; 1: a-b-cin
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  result mod 2^WIDTH
- cout  output  1  carry-out; in sub mode 1 = no borrow
- ovf  output  1  signed overflow
- zero  output  1  sum == 0

## Operation
- Sub mode implemented as a + ~b + !cin; cout is the raw carry of that sum.
- Stage k (0..S-1) adds slice k of a and b' plus the carry from stage k-1 (stage 0 uses the effective carry-in). Higher slices are delayed alongside; lower result slices are delayed to align.
- ovf = carry into MSB XOR carry out of MSB; computed in stage S-1.
- zero computed from the full aligned result in stage S-1.
- Per-stage valid bit; stage registers load only when the pipe advances.
- advance = !out_valid || out_ready; the whole pipe moves together (bubbles are not collapsed).
- in_ready = advance && !reset (combinational).
- Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
- Results emerge strictly in acceptance order; no loss or duplication under any out_ready pattern.

## Timing
- Reset: all valid bits 0; out_valid=0, sum=0, cout=0, ovf=0, zero=0; in_ready=0 while reset is high.
- Latency: beat accepted at edge t -> out_valid, sum, cout, ovf, zero visible after edge t+S-1 (S register stages), given no stall.
- Throughput: one beat per cycle while out_ready stays high.
- out_ready low with out_valid high: all stages hold, outputs stable, in_ready low.
- Simultaneous out accept and in accept in the same cycle: both occur; full rate is sustained.
- When out_valid is low, sum, cout, ovf and zero hold their last values and are don't-care to consumers.
- Reset asserted mid-operation: all in-flight beats are discarded at that edge; the next valid output is from a beat accepted after reset deasserts.
- S=1 (CHUNK=WIDTH) is legal: single registered stage, latency 1.

## Structure
- Shared include/package: default WIDTH/CHUNK constants and the derived stage-count function; reused by the CPU datapath.
- One sub-module, adder_chunk: combinational CHUNK-bit slice add (a, b, cin -> s, cout, carry into MSB), instantiated S times by a generate loop. The stage registers stay in adder_pipe.

## Test plan
- Add, defaults, out_ready=1: a=0, b=15, cin=0 -> out_valid 3 edges after accept, sum=0x0000000F, cout=0, zero=0.
- Carry across every slice: a=0xFFFFFFFF, b=1 -> sum=0, cout=1, zero=1, ovf=0. a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1.
- Subtract: sub=1, a=5, b=7, cin=0 -> sum=0xFFFFFFFE, cout=0. a=7, b=5, cin=1 -> sum=1, cout=1.
- Streaming with backpressure: 100 beats where a and b both step by 0x1FFFFFFF each beat from a=0, b=15; out_ready random -> every result equals a+b mod 2^32, in order, and outputs hold stable while stalled.
- Reset with 3 beats in flight -> out_valid=0 the cycle after, none of those results ever appear; the first post-reset beat has normal latency.
- Parameter sweep: WIDTH=16/CHUNK=16, and WIDTH=64/CHUNK=8 -> latency 1 and 8 respectively; random results match the reference sum.
